// File: rtl/sparse_dist_net.sv
// sparse_dist_net
//
// Two-stage, fully pipelined sparse distribution network. Each accepted beat
// carries N_IN data elements plus one source index per output lane; every
// output lane picks one element (or the element named by lane 0 in broadcast
// mode). Out-of-range indices and masked lanes produce zero.
//
// Pipeline:
//   S1 - registers the raw beat (in, idx, bcast and, if enabled, lane_mask).
//   S2 - registers the selected lane data; drives out / out_valid directly.
// With out_ready held high a beat accepted in cycle c is on out in cycle c+2,
// at one beat per clock.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   input beat valid
//   in_ready   block accepts an input beat this cycle (no path from in_valid)
//   in         N_IN elements, element k at [k*DW_DATA +: DW_DATA]
//   idx        per-lane source index, lane j at [j*DW_IDX +: DW_IDX]
//   bcast      all lanes take the element selected by lane 0's index
//   lane_mask  per-lane zero mask (only with DN_ZERO_MASK_EN)
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out        N_OUT lanes, lane j at [j*DW_DATA +: DW_DATA]
//
// Build option:
//   DN_ZERO_MASK_EN - when defined, adds the lane_mask port; a lane whose mask
//                     bit is 1 outputs zero. Undefined: no port, no masking.

module sparse_dist_net #(
    parameter int unsigned DW_DATA = 8,
    parameter int unsigned N_IN    = 8,
    parameter int unsigned N_OUT   = 32,
    parameter int unsigned DW_IDX  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DW_DATA-1:0]    in,
    input  logic [N_OUT*DW_IDX-1:0]    idx,
    input  logic                       bcast,
`ifdef DN_ZERO_MASK_EN
    input  logic [N_OUT-1:0]           lane_mask,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_OUT*DW_DATA-1:0]   out
);

    // Every value an index can take; entries at or above N_IN read as zero.
    localparam int unsigned NSel = 2 ** DW_IDX;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                       s1_valid_q, s1_valid_d;
    logic [N_IN*DW_DATA-1:0]    s1_in_q,    s1_in_d;
    logic [N_OUT*DW_IDX-1:0]    s1_idx_q,   s1_idx_d;
    logic                       s1_bcast_q, s1_bcast_d;
    logic [N_OUT-1:0]           s1_mask_q,  s1_mask_d;

    logic                       s2_valid_q, s2_valid_d;
    logic [N_OUT*DW_DATA-1:0]   s2_data_q,  s2_data_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s2_free;      // S2 can take a new beat this cycle
    logic s1_advance;   // S1 beat moves into S2 this cycle
    logic in_fire;      // input transfer
    logic [N_OUT-1:0] mask_in;

`ifdef DN_ZERO_MASK_EN
    assign mask_in = lane_mask;
`else
    assign mask_in = '0;
`endif

    // S2 frees up when empty or its beat is taken this cycle; in_ready then
    // depends only on stage state and out_ready, never on in_valid.
    assign s2_free    = !s2_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_free;
    assign in_ready   = !s1_valid_q || s2_free;
    assign in_fire    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Lane selection (from S1 contents)
    // ------------------------------------------------------------------
    logic [DW_DATA-1:0]         elem_tbl [NSel];
    logic [N_OUT*DW_DATA-1:0]   sel_data;

    for (genvar k = 0; k < NSel; k++) begin : g_elem
        if (k < N_IN) begin : g_real
            assign elem_tbl[k] = s1_in_q[k*DW_DATA +: DW_DATA];
        end else begin : g_zero
            assign elem_tbl[k] = '0;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        logic [DW_IDX-1:0] lane_sel;

        // Broadcast reuses lane 0's index for every lane.
        assign lane_sel = s1_bcast_q ? s1_idx_q[DW_IDX-1:0]
                                     : s1_idx_q[j*DW_IDX +: DW_IDX];
        assign sel_data[j*DW_DATA +: DW_DATA] = s1_mask_q[j] ? '0 : elem_tbl[lane_sel];
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_in_d    = s1_in_q;
        s1_idx_d   = s1_idx_q;
        s1_bcast_d = s1_bcast_q;
        s1_mask_d  = s1_mask_q;

        // Data and index are captured together so a stalled beat is immune
        // to later changes on the idx/in inputs.
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_in_d    = in;
            s1_idx_d   = idx;
            s1_bcast_d = bcast;
            s1_mask_d  = mask_in;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_in_q    <= '0;
            s1_idx_q   <= '0;
            s1_bcast_q <= 1'b0;
            s1_mask_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_in_q    <= s1_in_d;
            s1_idx_q   <= s1_idx_d;
            s1_bcast_q <= s1_bcast_d;
            s1_mask_q  <= s1_mask_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = s2_data_q;

endmodule

// File: tb/tb_sparse_dist_net.sv
// Self-checking bench for sparse_dist_net. A queue-based model tracks beats in
// flight; the compare process checks in_ready, out_valid and out every cycle.
// Directed sections pin the model with hand-computed literal values.

module tb_sparse_dist_net;

    localparam int DW  = 8;
    localparam int NI  = 8;
    localparam int NO  = 32;
    localparam int DI  = 3;
    localparam int NI6 = 6;
    localparam int NO6 = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, bcast, out_valid, out_ready;
    logic [NI*DW-1:0] din;
    logic [NO*DI-1:0] idx;
    logic [NO*DW-1:0] dout;
    logic [NO-1:0]    mask_s;

    logic              v6, rdy6, ov6;
    logic [NI6*DW-1:0] in6;
    logic [NO6*DI-1:0] idx6;
    logic [NO6*DW-1:0] out6;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sparse_dist_net #(.DW_DATA(DW), .N_IN(NI), .N_OUT(NO), .DW_IDX(DI)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .idx       (idx),
        .bcast     (bcast),
`ifdef DN_ZERO_MASK_EN
        .lane_mask (mask_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
    );

    logic [NO6-1:0] mask6 = '0;

    sparse_dist_net #(.DW_DATA(DW), .N_IN(NI6), .N_OUT(NO6), .DW_IDX(DI)) dut6 (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (v6),
        .in_ready  (rdy6),
        .in        (in6),
        .idx       (idx6),
        .bcast     (1'b0),
`ifdef DN_ZERO_MASK_EN
        .lane_mask (mask6),
`endif
        .out_valid (ov6),
        .out_ready (1'b1),
        .out       (out6)
    );

    task automatic chk(input string nm, input logic [NO*DW-1:0] act,
                       input logic [NO*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: lane j takes element idx_j (or idx_0 in broadcast); zero when
    // the index names no element or the lane is masked.
    function automatic logic [NO*DW-1:0] model(input logic [NI*DW-1:0] d,
                                               input logic [NO*DI-1:0] ix,
                                               input logic b, input logic [NO-1:0] m);
        logic [NO*DW-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < NO; j++) begin
            s = b ? int'(ix[DI-1:0]) : int'(ix[j*DI +: DI]);
            if (!m[j] && s < NI) r[j*DW +: DW] = d[s*DW +: DW];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard / compare process
    // ------------------------------------------------------------------
    logic [NO*DW-1:0] exp_q [$];
    int               acc_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            chk("rst_out_valid", NO'(out_valid), '0);
            chk("rst_out", dout, '0);
            chk("rst_in_ready", NO'(in_ready), NO'(1));
        end else begin
            // At most two beats in flight; with two, only a draining S2 frees space.
            chk("in_ready", NO'(in_ready), NO'((exp_q.size() < 2) || out_ready));
            chk("out_valid", NO'(out_valid),
                NO'(exp_q.size() > 0 && acc_q[0] + 2 <= cyc));
            if (out_valid && exp_q.size() > 0) chk("out_data", dout, exp_q[0]);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(din, idx, bcast, mask_s));
                acc_q.push_back(cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        for (int k = 0; k < NI; k++) din[k*DW +: DW] = 8'($urandom);
        for (int j = 0; j < NO; j++) idx[j*DI +: DI] = 3'($urandom);
    endtask

    function automatic logic [NI*DW-1:0] ramp();
        logic [NI*DW-1:0] r;
        for (int k = 0; k < NI; k++) r[k*DW +: DW] = 8'(k);
        return r;
    endfunction

    int pat [8] = '{0, 2, 7, 1, 2, 5, 4, 6};
    logic [NO*DW-1:0] expv;
    int cnt, run, maxrun;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bcast = 1'b0;
        din = '0; idx = '0; mask_s = '0;
        v6 = 1'b0; in6 = '0; idx6 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", NO'(out_valid), '0);
        chk("reset_out", dout, '0);
        chk("reset_in_ready", NO'(in_ready), NO'(1));

        // Fixed pattern: lanes 0..7 = 0,2,7,1,2,5,4,6 repeated.
        rst_n = 1'b1;
        din = ramp();
        for (int j = 0; j < NO; j++) idx[j*DI +: DI] = 3'(pat[j % 8]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        for (int j = 0; j < NO; j++) expv[j*DW +: DW] = 8'(pat[j % 8]);
        chk("pattern_valid", NO'(out_valid), NO'(1));
        chk("pattern_lanes", dout, expv);
        repeat (3) step();

        // Broadcast of element 5.
        rand_beat();
        din = ramp();
        idx[DI-1:0] = 3'd5;
        bcast = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        bcast = 1'b0;
        step();
        expv = {NO{8'h05}};
        chk("bcast_lanes", dout, expv);
        repeat (3) step();

        // Ten back-to-back beats, identity indices.
        for (int j = 0; j < NO; j++) idx[j*DI +: DI] = 3'(j % 8);
        cnt = 0; run = 0; maxrun = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 10);
            din = ramp() + 64'(c);
            @(negedge clk);
            if (out_valid) begin
                cnt++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            step();
        end
        in_valid = 1'b0;
        chk("burst_count", NO'(cnt), NO'(10));
        chk("burst_no_gaps", NO'(maxrun), NO'(10));

        // Stall: out_ready low, inputs keep changing.
        out_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            rand_beat();
            @(negedge clk);
            if (in_valid && in_ready) cnt++;
            step();
        end
        chk("stall_accepted", NO'(cnt), NO'(2));
        chk("stall_in_ready", NO'(in_ready), '0);
        in_valid = 1'b0;
        rand_beat();
        out_ready = 1'b1;
        repeat (4) step();

`ifdef DN_ZERO_MASK_EN
        din = ramp();
        for (int j = 0; j < NO; j++) idx[j*DI +: DI] = 3'(pat[j % 8]);
        mask_s = 32'h0000_000F;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        mask_s = '0;
        step();
        for (int j = 0; j < NO; j++) expv[j*DW +: DW] = (j < 4) ? 8'd0 : 8'(pat[j % 8]);
        chk("mask_lanes", dout, expv);
        repeat (3) step();
`endif

        // Randomised traffic; the compare process does all the checking.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            bcast     = ($urandom % 8) == 0;
`ifdef DN_ZERO_MASK_EN
            mask_s    = ($urandom % 4 == 0) ? NO'($urandom) : '0;
`endif
            rand_beat();
            step();
        end
        in_valid = 1'b0; bcast = 1'b0; out_ready = 1'b1; mask_s = '0;
        repeat (4) step();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            rand_beat();
            step();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", NO'(out_valid), '0);
        chk("midrst_out", dout, '0);
        chk("midrst_in_ready", NO'(in_ready), NO'(1));
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) cnt++;
            step();
        end
        chk("no_stale_beats", NO'(cnt), '0);
        // First beat after release flows normally (scoreboard checks data).
        rand_beat();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_valid", NO'(out_valid), NO'(1));
        repeat (3) step();

        // N_IN=6 instance: indices 7 and 6 are out of range.
        in6 = {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10};
        idx6 = {3'd0, 3'd5, 3'd6, 3'd7};
        v6 = 1'b1;
        step();
        v6 = 1'b0;
        step();
        chk("nin6_valid", NO'(ov6), NO'(1));
        chk("nin6_lanes", NO'(out6), NO'(32'h0A0F_0000));
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
